// File: rtl/qlf_k4n8_cfg_loader.sv
// Configuration-chain loader for a K4N8 logic block: serialises words LSB-first into
// the scff chain while capturing the chain tail as readback words.
module qlf_k4n8_cfg_loader #(
  parameter int unsigned CHAIN_LEN = 160,
  parameter int unsigned WORD_W    = 16
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              chain_head,
  output logic              chain_en,
  input  logic              chain_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BC_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WB_W = $clog2(WORD_W + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0] WB_LAST = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] r_rbreg;
  logic [WORD_W-1:0] r_rb_data;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WB_W-1:0]   r_wbit;
  logic              r_in_ready;
  logic              r_chain_en;
  logic              r_rb_valid;
  logic              r_busy;
  logic              r_done;

  logic [WORD_W-1:0] w_rb_next;
  logic              w_last_bit;
  logic              w_word_end;

  // Readback word including the tail bit sampled on this edge.
  always_comb begin
    w_rb_next  = r_rbreg | (WORD_W'(chain_tail) << r_wbit);
    w_last_bit = (r_bit_cnt == BC_LAST);
    w_word_end = (r_wbit == WB_LAST);
  end

  always_ff @(posedge clk) begin
    if (R) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_rbreg    <= '0;
      r_rb_data  <= '0;
      r_bit_cnt  <= '0;
      r_wbit     <= '0;
      r_in_ready <= 1'b0;
      r_chain_en <= 1'b0;
      r_rb_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_bit_cnt  <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_shreg    <= in_data;
            r_wbit     <= '0;
            r_rbreg    <= '0;
            r_state    <= S_SHIFT;
            r_in_ready <= 1'b0;
            r_chain_en <= 1'b1;
          end
        end
        S_SHIFT: begin
          r_shreg   <= r_shreg >> 1;
          r_rbreg   <= w_rb_next;
          r_wbit    <= r_wbit + 1'b1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          // Chain end takes priority so a short last word ends the frame early.
          if (w_last_bit) begin
            r_state    <= S_DONE;
            r_chain_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_rb_data  <= w_rb_next;
            r_rb_valid <= 1'b1;
          end else if (w_word_end) begin
            r_state    <= S_LOAD;
            r_chain_en <= 1'b0;
            r_in_ready <= 1'b1;
            r_rb_data  <= w_rb_next;
            r_rb_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign chain_en   = r_chain_en;
  assign chain_head = r_chain_en & r_shreg[0];
  assign rb_data    = r_rb_data;
  assign rb_valid   = r_rb_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_qlf_k4n8_cfg_loader.sv
// Bench for qlf_k4n8_cfg_loader: 20-bit/8-bit and 16-bit/16-bit configurations driving
// behavioural scff chains; readback checked against the previously loaded bit stream.
module tb_qlf_k4n8_cfg_loader;

  logic clk;
  logic R;

  logic       start, in_valid, in_ready, chain_head, chain_en, chain_tail;
  logic [7:0] in_data, rb_data;
  logic       rb_valid, busy, done;

  logic        start2, in_valid2, ready2, head2, en2, tail2;
  logic [15:0] in_data2, rb2;
  logic        rbv2, busy2, done2;

  qlf_k4n8_cfg_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut (
    .clk(clk), .R(R), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .chain_head(chain_head), .chain_en(chain_en),
    .chain_tail(chain_tail), .rb_data(rb_data), .rb_valid(rb_valid),
    .busy(busy), .done(done)
  );

  qlf_k4n8_cfg_loader #(.CHAIN_LEN(16), .WORD_W(16)) dut2 (
    .clk(clk), .R(R), .start(start2), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(ready2), .chain_head(head2), .chain_en(en2),
    .chain_tail(tail2), .rb_data(rb2), .rb_valid(rbv2),
    .busy(busy2), .done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural scff chains: shift in at the head, tail is the last flop's Q.
  logic [19:0] scff  = 20'hFFFFF;
  logic [15:0] scff2 = 16'hFFFF;
  always @(posedge clk) if (chain_en) scff  <= {scff[18:0], chain_head};
  always @(posedge clk) if (en2)      scff2 <= {scff2[14:0], head2};
  assign chain_tail = scff[19];
  assign tail2      = scff2[15];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  bit         mon_on = 1'b0;
  bit         prev_en = 1'b0;
  int         bursts = 0;
  logic       q_head[$];
  logic [7:0] q_rb[$];

  always @(negedge clk) begin
    if (mon_on) begin
      if (chain_en) begin
        q_head.push_back(chain_head);
        if (!prev_en) bursts++;
      end
      prev_en = chain_en;
      if (rb_valid) q_rb.push_back(rb_data);
    end
  end

  task automatic send_word(input logic [7:0] d, input int stall);
    int g;
    bit ok;
    in_data = d;
    if (stall > 0) begin
      in_valid = 1'b0;
      g = 0;
      while (!in_ready && g < 100) begin @(negedge clk); g++; end
      ok = 1'b1;
      repeat (stall) begin
        if (!(in_ready && !chain_en && busy)) ok = 1'b0;
        @(negedge clk);
      end
      chk("stall_hold", 32'(ok), 32'd1);
    end
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin @(negedge clk); g++; end
    chk("ready_seen", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [23:0] words, input int stall, input bit poke,
                           input bit chk_rb, input logic [23:0] exp_rb,
                           input logic [19:0] exp_head);
    int t0, g;
    logic [19:0] got_head;
    logic [23:0] got_rb;
    q_head.delete();
    q_rb.delete();
    bursts  = 0;
    prev_en = 1'b0;
    mon_on  = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t0 = cyc;
    chk("frame_start", 32'({busy, done, in_ready}), 32'b101);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k*8 +: 8], (k == 0) ? 0 : stall);
      if (poke && k == 0) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("poke_busy", 32'({busy, in_ready, done}), 32'b100);
      end
    end
    g = 0;
    while (!done && g < 100) begin @(negedge clk); g++; end
    chk("done_seen", 32'(done), 32'd1);
    if (stall == 0) chk("done_latency", 32'(cyc - t0), 32'd23);
    @(negedge clk);
    chk("done_hold", 32'({done, busy, chain_en, in_ready}), 32'b1000);
    mon_on = 1'b0;
    got_head = '0;
    for (int i = 0; i < q_head.size() && i < 20; i++) got_head[i] = q_head[i];
    got_rb = '0;
    for (int k = 0; k < q_rb.size() && k < 3; k++) got_rb[k*8 +: 8] = q_rb[k];
    chk("en_cycles", 32'(q_head.size()), 32'd20);
    chk("en_bursts", 32'(bursts), 32'd3);
    chk("head_seq", 32'(got_head), 32'(exp_head));
    chk("rb_count", 32'(q_rb.size()), 32'd3);
    if (chk_rb) chk("rb_words", 32'(got_rb), 32'(exp_rb));
  endtask

  typedef struct {
    logic [23:0] words;
    int          stall;
    bit          poke;
    logic [23:0] rb;
    logic [19:0] head;
  } vec_t;

  vec_t        tbl[4];
  logic [23:0] w;
  logic [19:0] prev;
  bit          prev_known;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // words packed {w2,w1,w0}; rb packed {rb2,rb1,rb0}; head bit i = i-th bit shifted
    tbl[0] = '{words: 24'h0F3CA5, stall: 0, poke: 1'b0, rb: 24'h0FFFFF, head: 20'hF3CA5};
    tbl[1] = '{words: 24'h563412, stall: 5, poke: 1'b0, rb: 24'h0F3CA5, head: 20'h63412};
    tbl[2] = '{words: 24'hF700FF, stall: 0, poke: 1'b1, rb: 24'h063412, head: 20'h700FF};
    tbl[3] = '{words: 24'hAA8001, stall: 0, poke: 1'b0, rb: 24'h0700FF, head: 20'hA8001};

    R = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    start2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0;
    repeat (3) @(negedge clk);
    R = 1'b0;
    chk("rst_outs", 32'({in_ready, chain_en, chain_head, rb_valid, busy, done,
                         ready2, en2, head2, rbv2, busy2, done2}), 32'd0);
    chk("rst_rb", 32'({rb2, rb_data}), 32'd0);

    for (int i = 0; i < 4; i++)
      run_frame(tbl[i].words, tbl[i].stall, tbl[i].poke, 1'b1, tbl[i].rb, tbl[i].head);

    // Abort in the middle of the second word.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'({busy, chain_en}), 32'b11);
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    chk("rst_mid_outs", 32'({in_ready, chain_en, chain_head, rb_valid, busy, done}), 32'd0);
    chk("rst_mid_rb", 32'(rb_data), 32'd0);
    @(negedge clk);
    chk("rst_mid_idle", 32'({busy, in_ready}), 32'd0);

    prev_known = 1'b0;
    prev = '0;
    for (int f = 0; f < 6; f++) begin
      w = 24'($urandom);
      // Readback of a full frame is exactly the previous frame's bit stream.
      run_frame(w, $urandom_range(0, 3), 1'($urandom_range(0, 1)), prev_known,
                {4'h0, prev}, w[19:0]);
      prev = w[19:0];
      prev_known = 1'b1;
    end

    // Single full-width word exactly filling the chain.
    begin
      int n, g;
      logic first, last;
      logic [15:0] hv;
      n = 0; g = 0; first = 1'b0; last = 1'b0; hv = '0;
      @(negedge clk); start2 = 1'b1; in_data2 = 16'h8001; in_valid2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      while (!done2 && g < 100) begin
        if (en2) begin
          if (n == 0) first = head2;
          last = head2;
          if (n < 16) hv[n] = head2;
          n++;
        end
        @(negedge clk);
        g++;
      end
      in_valid2 = 1'b0;
      chk("w16_done", 32'({done2, busy2}), 32'b10);
      chk("w16_en_cycles", 32'(n), 32'd16);
      chk("w16_first_last", 32'({first, last}), 32'b11);
      chk("w16_head_seq", 32'(hv), 32'h8001);
      chk("w16_rb", 32'(rb2), 32'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
